// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetches, decodes IR[31:27] and sequences encoded bus/ALU/register
// controls, with memory handshake timeout, MUL/DIV wait, run/step control and halt/fault status.
module control_sequencer #(
  parameter int MUL_CYCLES  = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        con_ff,
  input  logic        run,
  input  logic        step,
  output logic [3:0]  bus_src,
  output logic [10:0] dst_en,
  output logic [1:0]  reg_sel,
  output logic [3:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        con_reset,
  output logic        pc_save,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [3:0] {
    ST_RST, ST_IDLE, ST_F0, ST_F1, ST_F2, ST_F3, ST_EXEC, ST_WAIT, ST_HALT, ST_FAULT
  } state_e;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;
  localparam logic [4:0] OP_ILL  = 5'd28;

  localparam logic [3:0] BUS_NONE = 4'd0, BUS_PC = 4'd1, BUS_MDR = 4'd2, BUS_ZLO = 4'd3;
  localparam logic [3:0] BUS_HI = 4'd5, BUS_LO = 4'd6, BUS_C = 4'd7, BUS_IN = 4'd8;
  localparam logic [3:0] BUS_RSEL = 4'd9, BUS_BA = 4'd10;

  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR = 4'd4, ALU_ROR = 4'd5, ALU_ROL = 4'd6, ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_SHRA = 4'd8, ALU_SHL = 4'd9, ALU_MUL = 4'd10, ALU_DIV = 4'd11;
  localparam logic [3:0] ALU_NEG = 4'd12, ALU_NOT = 4'd13, ALU_INC = 4'd14;

  localparam logic [1:0] REG_NONE = 2'd0, REG_GRA = 2'd1, REG_GRB = 2'd2, REG_GRC = 2'd3;

  localparam int D_PC = 0, D_IR = 1, D_MAR = 2, D_MDR = 3, D_Y = 4, D_Z = 5;
  localparam int D_HI = 6, D_LO = 7, D_CON = 8, D_OUT = 9, D_R = 10;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d, nxt_state_s, end_state_s;
  logic [2:0]       t_q, t_d, nxt_t_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt_s;
  logic [4:0]       op_q, op_d;
  logic             mem_wait_s;
  logic             unused_ir_s;

  assign unused_ir_s = ^IR[26:0];

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_of = ALU_ADD;
      OP_SUB:          alu_of = ALU_SUB;
      OP_AND, OP_ANDI: alu_of = ALU_AND;
      OP_OR, OP_ORI:   alu_of = ALU_OR;
      OP_ROR:          alu_of = ALU_ROR;
      OP_ROL:          alu_of = ALU_ROL;
      OP_SHR:          alu_of = ALU_SHR;
      OP_SHRA:         alu_of = ALU_SHRA;
      OP_SHL:          alu_of = ALU_SHL;
      OP_MUL:          alu_of = ALU_MUL;
      OP_DIV:          alu_of = ALU_DIV;
      OP_NEG:          alu_of = ALU_NEG;
      OP_NOT:          alu_of = ALU_NOT;
      default:         alu_of = ALU_NONE;
    endcase
  endfunction

  // State, step index, wait counter and latched opcode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      t_q     <= 3'd0;
      cnt_q   <= '0;
      op_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Moore decode of controls plus next-state selection.
  always_comb begin
    nxt_state_s = state_q;
    nxt_t_s     = t_q;
    nxt_cnt_s   = '0;
    op_d        = op_q;
    end_state_s = run ? ST_F0 : ST_IDLE;
    bus_src     = BUS_NONE;
    dst_en      = 11'd0;
    reg_sel     = REG_NONE;
    alu_op      = ALU_NONE;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    con_reset   = 1'b0;
    pc_save     = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_RST: begin
        busy        = 1'b0;
        con_reset   = 1'b1;
        nxt_state_s = end_state_s;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (run || step) nxt_state_s = ST_F0;
        else             nxt_state_s = ST_IDLE;
      end
      ST_F0: begin
        bus_src = BUS_PC; alu_op = ALU_INC; dst_en[D_MAR] = 1'b1; dst_en[D_Z] = 1'b1;
        nxt_state_s = ST_F1;
      end
      ST_F1: begin
        bus_src = BUS_ZLO; dst_en[D_PC] = 1'b1;
        nxt_state_s = ST_F2;
      end
      ST_F2: begin
        mem_read = 1'b1; dst_en[D_MDR] = 1'b1;
        nxt_state_s = ST_F3;
      end
      ST_F3: begin
        bus_src = BUS_MDR; dst_en[D_IR] = 1'b1;
        op_d    = IR[31:27];
        nxt_t_s = 3'd0;
        if (IR[31:27] >= OP_ILL) nxt_state_s = ST_FAULT;
        else                     nxt_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        nxt_t_s = t_q + 3'd1;
        case (op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT: begin
            case (t_q)
              3'd0: begin bus_src = BUS_RSEL; reg_sel = REG_GRB; dst_en[D_Y] = 1'b1; end
              3'd1: begin
                alu_op = alu_of(op_q); dst_en[D_Z] = 1'b1;
                if (op_q == OP_ADDI || op_q == OP_ANDI || op_q == OP_ORI) begin
                  bus_src = BUS_C;
                end else begin
                  bus_src = BUS_RSEL;
                  reg_sel = (op_q == OP_NEG || op_q == OP_NOT) ? REG_GRB : REG_GRC;
                end
              end
              3'd2: begin
                bus_src = BUS_ZLO; reg_sel = REG_GRA; dst_en[D_R] = 1'b1;
                nxt_state_s = end_state_s;
              end
              default: nxt_state_s = ST_FAULT;
            endcase
          end
          // Effective address is Grb (or 0 for r0) + C, formed through Y/Z.
          OP_LD, OP_LDI, OP_ST: begin
            case (t_q)
              3'd0: begin bus_src = BUS_BA; reg_sel = REG_GRB; dst_en[D_Y] = 1'b1; end
              3'd1: begin bus_src = BUS_C; alu_op = ALU_ADD; dst_en[D_Z] = 1'b1; end
              3'd2: begin
                bus_src = BUS_ZLO;
                if (op_q == OP_LDI) begin
                  reg_sel = REG_GRA; dst_en[D_R] = 1'b1; nxt_state_s = end_state_s;
                end else begin
                  dst_en[D_MAR] = 1'b1;
                end
              end
              3'd3: begin
                dst_en[D_MDR] = 1'b1;
                if (op_q == OP_LD) mem_read = 1'b1;
                else begin bus_src = BUS_RSEL; reg_sel = REG_GRA; end
              end
              3'd4: begin
                nxt_state_s = end_state_s;
                if (op_q == OP_LD) begin
                  bus_src = BUS_MDR; reg_sel = REG_GRA; dst_en[D_R] = 1'b1;
                end else begin
                  mem_write = 1'b1;
                end
              end
              default: nxt_state_s = ST_FAULT;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (t_q)
              3'd0: begin bus_src = BUS_RSEL; reg_sel = REG_GRA; dst_en[D_Y] = 1'b1; end
              3'd1: begin
                bus_src = BUS_RSEL; reg_sel = REG_GRB; alu_op = alu_of(op_q); dst_en[D_Z] = 1'b1;
                nxt_cnt_s   = (op_q == OP_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                nxt_state_s = ST_WAIT;
              end
              3'd2: begin
                dst_en[D_HI] = 1'b1; dst_en[D_LO] = 1'b1;
                nxt_state_s = end_state_s;
              end
              default: nxt_state_s = ST_FAULT;
            endcase
          end
          OP_BR: begin
            case (t_q)
              3'd0: begin bus_src = BUS_RSEL; reg_sel = REG_GRA; dst_en[D_CON] = 1'b1; end
              3'd1: begin bus_src = BUS_PC; dst_en[D_Y] = 1'b1; end
              3'd2: begin bus_src = BUS_C; alu_op = ALU_ADD; dst_en[D_Z] = 1'b1; end
              3'd3: begin bus_src = BUS_ZLO; dst_en[D_PC] = con_ff; end
              3'd4: begin con_reset = 1'b1; nxt_state_s = end_state_s; end
              default: nxt_state_s = ST_FAULT;
            endcase
          end
          OP_JAL: begin
            case (t_q)
              3'd0: begin pc_save = 1'b1; bus_src = BUS_PC; dst_en[D_R] = 1'b1; end
              3'd1: begin
                bus_src = BUS_RSEL; reg_sel = REG_GRA; dst_en[D_PC] = 1'b1;
                nxt_state_s = end_state_s;
              end
              default: nxt_state_s = ST_FAULT;
            endcase
          end
          OP_JR: begin
            bus_src = BUS_RSEL; reg_sel = REG_GRA; dst_en[D_PC] = 1'b1;
            nxt_state_s = end_state_s;
          end
          OP_IN: begin
            bus_src = BUS_IN; reg_sel = REG_GRA; dst_en[D_R] = 1'b1;
            nxt_state_s = end_state_s;
          end
          OP_OUT: begin
            bus_src = BUS_RSEL; reg_sel = REG_GRA; dst_en[D_OUT] = 1'b1;
            nxt_state_s = end_state_s;
          end
          OP_MFHI, OP_MFLO: begin
            bus_src = (op_q == OP_MFHI) ? BUS_HI : BUS_LO; reg_sel = REG_GRA; dst_en[D_R] = 1'b1;
            nxt_state_s = end_state_s;
          end
          OP_NOP:  nxt_state_s = end_state_s;
          OP_HALT: nxt_state_s = ST_HALT;
          default: nxt_state_s = ST_FAULT;
        endcase
      end
      ST_WAIT: begin
        alu_op = alu_of(op_q);
        if (cnt_q <= CNT_W'(1)) begin
          nxt_state_s = ST_EXEC;
          nxt_t_s     = 3'd2;
        end else begin
          nxt_cnt_s = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        busy = 1'b0; halted = 1'b1;
      end
      ST_FAULT: begin
        busy = 1'b0; fault = 1'b1;
      end
      default: begin
        busy = 1'b0; nxt_state_s = ST_FAULT;
      end
    endcase

    // Any memory step stalls until mem_ready; ready on the last allowed cycle still wins.
    mem_wait_s = (mem_read || mem_write) && !mem_ready;
    if (!mem_wait_s) begin
      state_d = nxt_state_s; t_d = nxt_t_s; cnt_d = nxt_cnt_s;
    end else if (cnt_q >= TMO_LAST) begin
      state_d = ST_FAULT; t_d = 3'd0; cnt_d = '0;
    end else begin
      state_d = state_q; t_d = t_q; cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected control-word sequences built from the
// instruction semantics, compared cycle by cycle against control_sequencer.
module tb_control_sequencer;

  localparam int MULC = 4;
  localparam int DIVC = 6;
  localparam int TO   = 15;

  localparam int D_PC = 1, D_IR = 2, D_MAR = 4, D_MDR = 8, D_Y = 16, D_Z = 32;
  localparam int D_HI = 64, D_LO = 128, D_CON = 256, D_OUT = 512, D_R = 1024;

  localparam logic [27:0] MR     = 28'h40;
  localparam logic [27:0] MW     = 28'h20;
  localparam logic [27:0] CR     = 28'h10;
  localparam logic [27:0] PS     = 28'h08;
  localparam logic [27:0] RSTV   = 28'h10;
  localparam logic [27:0] IDLEV  = 28'h00;
  localparam logic [27:0] HALTV  = 28'h02;
  localparam logic [27:0] FAULTV = 28'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        mem_ready = 1'b0, con_ff = 1'b0, run = 1'b1, step = 1'b0;
  logic [3:0]  bus_src, alu_op;
  logic [10:0] dst_en;
  logic [1:0]  reg_sel;
  logic        mem_read, mem_write, con_reset, pc_save, busy, halted, fault;
  logic [27:0] obs;

  int total = 0;
  int bad   = 0;
  int fetch_cnt = 0;

  logic [27:0] exp_q[$];
  bit          rdy_q[$];

  control_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .MEM_TIMEOUT(TO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready), .con_ff(con_ff), .run(run),
    .step(step), .bus_src(bus_src), .dst_en(dst_en), .reg_sel(reg_sel), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .con_reset(con_reset), .pc_save(pc_save),
    .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {bus_src, dst_en, reg_sel, alu_op, mem_read, mem_write, con_reset, pc_save,
                busy, halted, fault};

  always @(posedge clk)
    if (bus_src == 4'd1 && alu_op == 4'd14) fetch_cnt <= fetch_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Control word: bus source, load enables, register select, ALU op, busy=1.
  function automatic logic [27:0] cw(input int bus, input int dst, input int sel, input int alu);
    logic [27:0] v;
    v = 28'd0;
    v[27:24] = bus[3:0];
    v[23:13] = dst[10:0];
    v[12:11] = sel[1:0];
    v[10:7]  = alu[3:0];
    v[2]     = 1'b1;
    return v;
  endfunction

  function automatic void add_step(input logic [27:0] v, input bit rdy);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
  endfunction

  // d idle cycles before mem_ready; d >= TO means memory never answers.
  function automatic bit add_mem(input logic [27:0] v, input int d);
    for (int i = 0; i < d && i < TO; i++) add_step(v, 1'b0);
    if (d >= TO) begin
      add_step(FAULTV, 1'b0);
      return 1'b1;
    end
    add_step(v, 1'b1);
    return 1'b0;
  endfunction

  function automatic int alu_code(input int op);
    if (op >= 3 && op <= 11) return op - 2;
    if (op == 12) return 1;
    if (op == 13) return 3;
    if (op == 14) return 4;
    if (op == 15) return 10;
    if (op == 16) return 11;
    if (op == 17) return 12;
    if (op == 18) return 13;
    return 0;
  endfunction

  function automatic void model_instr(input int op, input int fd, input int md, input bit con);
    int n;
    add_step(cw(1, D_MAR | D_Z, 0, 14), 1'b0);
    add_step(cw(3, D_PC, 0, 0), 1'b0);
    if (add_mem(cw(0, D_MDR, 0, 0) | MR, fd)) return;
    add_step(cw(2, D_IR, 0, 0), 1'b0);
    if (op >= 28) begin
      add_step(FAULTV, 1'b0);
      return;
    end
    if ((op >= 3 && op <= 14) || op == 17 || op == 18) begin
      add_step(cw(9, D_Y, 2, 0), 1'b0);
      if (op >= 12 && op <= 14) add_step(cw(7, D_Z, 0, alu_code(op)), 1'b0);
      else add_step(cw(9, D_Z, (op >= 17) ? 2 : 3, alu_code(op)), 1'b0);
      add_step(cw(3, D_R, 1, 0), 1'b0);
    end else if (op <= 2) begin
      add_step(cw(10, D_Y, 2, 0), 1'b0);
      add_step(cw(7, D_Z, 0, 1), 1'b0);
      if (op == 1) add_step(cw(3, D_R, 1, 0), 1'b0);
      else begin
        add_step(cw(3, D_MAR, 0, 0), 1'b0);
        if (op == 0) begin
          if (add_mem(cw(0, D_MDR, 0, 0) | MR, md)) return;
          add_step(cw(2, D_R, 1, 0), 1'b0);
        end else begin
          add_step(cw(9, D_MDR, 1, 0), 1'b0);
          if (add_mem(cw(0, 0, 0, 0) | MW, md)) return;
        end
      end
    end else if (op == 15 || op == 16) begin
      n = (op == 15) ? MULC : DIVC;
      add_step(cw(9, D_Y, 1, 0), 1'b0);
      add_step(cw(9, D_Z, 2, alu_code(op)), 1'b0);
      for (int i = 0; i < n; i++) add_step(cw(0, 0, 0, alu_code(op)), 1'b0);
      add_step(cw(0, D_HI | D_LO, 0, 0), 1'b0);
    end else if (op == 19) begin
      add_step(cw(9, D_CON, 1, 0), 1'b0);
      add_step(cw(1, D_Y, 0, 0), 1'b0);
      add_step(cw(7, D_Z, 0, 1), 1'b0);
      add_step(cw(3, con ? D_PC : 0, 0, 0), 1'b0);
      add_step(cw(0, 0, 0, 0) | CR, 1'b0);
    end else if (op == 20) add_step(cw(9, D_PC, 1, 0), 1'b0);
    else if (op == 21) begin
      add_step(cw(1, D_R, 0, 0) | PS, 1'b0);
      add_step(cw(9, D_PC, 1, 0), 1'b0);
    end else if (op == 22) add_step(cw(8, D_R, 1, 0), 1'b0);
    else if (op == 23) add_step(cw(9, D_OUT, 1, 0), 1'b0);
    else if (op == 24) add_step(cw(5, D_R, 1, 0), 1'b0);
    else if (op == 25) add_step(cw(6, D_R, 1, 0), 1'b0);
    else if (op == 26) add_step(cw(0, 0, 0, 0), 1'b0);
    else begin
      add_step(cw(0, 0, 0, 0), 1'b0);
      add_step(HALTV, 1'b0);
    end
  endfunction

  task automatic play_n(input string tag, input int n);
    int k;
    k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      step = 1'b0;
      #1;
      chk(tag, obs, exp_q.pop_front());
      k++;
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic instr(input string tag, input int op, input int fd, input int md, input bit con);
    IR = {op[4:0], 27'($urandom)};
    con_ff = con;
    model_instr(op, fd, md, con);
    play_n(tag, -1);
  endtask

  task automatic do_reset(input bit r);
    @(negedge clk);
    reset = 1'b0; run = r; step = 1'b0; mem_ready = 1'b0;
    #1 chk("reset", obs, RSTV);
    @(negedge clk);
    #1 chk("reset_hold", obs, RSTV);
    reset = 1'b1;
  endtask

  initial begin
    int op, fd, md, f0;

    do_reset(1'b1);

    instr("add", 3, 0, 0, 1'b0);
    instr("mul", 15, 0, 0, 1'b0);
    instr("div", 16, 2, 0, 1'b0);
    instr("br_con0", 19, 0, 0, 1'b0);
    instr("br_con1", 19, 0, 0, 1'b1);
    instr("ld_ready_last", 0, 0, TO - 1, 1'b0);
    instr("fetch_ready_last", 26, TO - 1, 0, 1'b0);
    instr("st", 2, 1, 3, 1'b0);
    instr("jal", 21, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 26);
      fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : 0;
      md = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO - 1) : 0;
      instr("rand", op, fd, md, 1'($urandom_range(0, 1)));
    end

    instr("illegal", 28 + $urandom_range(0, 3), 0, 0, 1'b0);
    repeat (2) begin
      @(negedge clk); #1 chk("illegal_hold", obs, FAULTV);
    end

    do_reset(1'b1);
    instr("ld_timeout", 0, 0, TO, 1'b0);
    repeat (2) begin
      @(negedge clk); #1 chk("timeout_hold", obs, FAULTV);
    end

    // Asynchronous abort while a fetch read is outstanding.
    do_reset(1'b1);
    IR = 32'h18918000;
    model_instr(3, 5, 0, 1'b0);
    play_n("pre_abort", 3);
    #2 reset = 1'b0;
    #1 chk("abort_midf2", obs, RSTV);
    @(negedge clk);
    reset = 1'b1;
    instr("after_abort", 3, 0, 0, 1'b0);

    // Stopped mode: idle until stepped, one instruction per step.
    do_reset(1'b0);
    @(negedge clk); #1 chk("idle_after_reset", obs, IDLEV);
    f0 = fetch_cnt;
    repeat (2) begin
      @(negedge clk); #1 chk("idle_wait", obs, IDLEV);
    end
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      instr("stepped", (s == 0) ? 3 : 23, 0, 0, 1'b0);
      repeat (3) begin
        @(negedge clk); #1 chk("idle_after_step", obs, IDLEV);
      end
    end
    chk("two_fetches", 28'(fetch_cnt - f0), 28'd2);

    step = 1'b1;
    IR = 32'hD8000000;
    model_instr(27, 0, 0, 1'b0);
    play_n("halt", -1);
    repeat (4) begin
      @(negedge clk);
      run = 1'b1; step = ~step;
      #1 chk("halt_hold", obs, HALTV);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_from_halt", obs, RSTV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
